call_return_unwinder: RTL

- Control-side counterpart to the function call-stack datapath. It sequences CALL (push a frame) and RET (pop a frame and restore it) for the stack processor.
- A frame is {return PC, data-stack TOS}. Frames live in an internal synchronous-read stack memory.
- On RET, the block latches the function's return value and presents the restored PC/TOS to the fetch and stack-pointer logic.
- Reports overflow and underflow through sticky error flags.

---
 rtl/call_return_unwinder_if.sv | 33 +++
 rtl/call_return_unwinder.sv | 131 +++++++++++++
 2 files changed

// File: rtl/call_return_unwinder_if.sv
// Request/response bundle between the stack processor control and the call/return unwinder.
// The master side issues CALL/RET requests; the slave side reports status and restored frames.
interface call_return_unwinder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH_LOG2 = 4
);
  logic                  call_req;
  logic                  ret_req;
  logic [ADDR_WIDTH-1:0] call_pc;
  logic [ADDR_WIDTH-1:0] call_tos;
  logic [DATA_WIDTH-1:0] ret_val_in;
  logic                  err_clr;

  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] restore_pc;
  logic [ADDR_WIDTH-1:0] restore_tos;
  logic [DATA_WIDTH-1:0] ret_val_out;
  logic [DEPTH_LOG2:0]   depth;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output call_req, ret_req, call_pc, call_tos, ret_val_in, err_clr,
    input  busy, done, restore_pc, restore_tos, ret_val_out, depth, overflow, underflow
  );

  modport slave (
    input  call_req, ret_req, call_pc, call_tos, ret_val_in, err_clr,
    output busy, done, restore_pc, restore_tos, ret_val_out, depth, overflow, underflow
  );
endinterface

// File: rtl/call_return_unwinder.sv
// Sequences CALL (push {return PC, TOS}) and RET (pop and restore) over a synchronous-read
// frame stack, latching the return value and keeping sticky overflow/underflow flags.
module call_return_unwinder #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH_LOG2 = 4
) (
  input logic clk,
  input logic reset,
  call_return_unwinder_if.slave bus
);

  localparam int FRAME_W = 2 * ADDR_WIDTH;
  localparam logic [DEPTH_LOG2:0] CAPACITY = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] SP_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RET_RD, RET_LOAD, DONE} state_t;

  state_t                 state;
  logic [DEPTH_LOG2:0]    sp;
  logic [FRAME_W-1:0]     mem [2**DEPTH_LOG2];
  logic [FRAME_W-1:0]     rd_data;
  logic [DATA_WIDTH-1:0]  held_val;
  logic [DATA_WIDTH-1:0]  ret_val_r;
  logic [ADDR_WIDTH-1:0]  restore_pc_r;
  logic [ADDR_WIDTH-1:0]  restore_tos_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   overflow_r;
  logic                   underflow_r;

  logic                   full;
  logic                   empty;
  logic [DEPTH_LOG2-1:0]  sp_idx;
  logic                   push_ok;
  logic                   call_ovf;
  logic                   ret_unf;

  assign full     = (sp == CAPACITY);
  assign empty    = (sp == '0);
  assign sp_idx   = sp[DEPTH_LOG2-1:0];
  // CALL has priority, so a RET is only considered when call_req is low.
  assign push_ok  = (state == IDLE) && bus.call_req && !full;
  assign call_ovf = (state == IDLE) && bus.call_req && full;
  assign ret_unf  = (state == IDLE) && !bus.call_req && bus.ret_req && empty;

  // Frame storage is never reset; the read in RET_RD uses the already-decremented sp.
  always_ff @(posedge clk) begin
    if (!reset && push_ok)
      mem[sp_idx] <= {bus.call_pc, bus.call_tos};
    if (state == RET_RD)
      rd_data <= mem[sp_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      sp            <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      held_val      <= '0;
      ret_val_r     <= '0;
      restore_pc_r  <= '0;
      restore_tos_r <= '0;
      overflow_r    <= 1'b0;
      underflow_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;

      // A new error in the same cycle as err_clr leaves the flag set.
      if (call_ovf)
        overflow_r <= 1'b1;
      else if (bus.err_clr)
        overflow_r <= 1'b0;

      if (ret_unf)
        underflow_r <= 1'b1;
      else if (bus.err_clr)
        underflow_r <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.call_req) begin
            if (!full)
              sp <= sp + SP_ONE;
            state  <= DONE;
            busy_r <= 1'b1;
            done_r <= 1'b1;
          end else if (bus.ret_req) begin
            busy_r <= 1'b1;
            if (!empty) begin
              sp       <= sp - SP_ONE;
              held_val <= bus.ret_val_in;
              state    <= RET_RD;
            end else begin
              state  <= DONE;
              done_r <= 1'b1;
            end
          end
        end
        RET_RD: begin
          state <= RET_LOAD;
        end
        RET_LOAD: begin
          {restore_pc_r, restore_tos_r} <= rd_data;
          ret_val_r <= held_val;
          state     <= DONE;
          done_r    <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.restore_pc  = restore_pc_r;
  assign bus.restore_tos = restore_tos_r;
  assign bus.ret_val_out = ret_val_r;
  assign bus.depth       = sp;
  assign bus.overflow    = overflow_r;
  assign bus.underflow   = underflow_r;

endmodule
